// File: rtl/axi_pkg.sv
// Shared AXI4 read-side types and constants for the memory responder.
package axi_pkg;

    typedef enum logic [1:0] {
        AXI_BURST_FIXED = 2'b00,
        AXI_BURST_INCR  = 2'b01,
        AXI_BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_8B     = 3'b011;

    typedef enum logic [1:0] {
        RSP_IDLE  = 2'b00,
        RSP_LAT   = 2'b01,
        RSP_BURST = 2'b10
    } rsp_state_e;

    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Beat address sequencer: presents the address/last flag of the beat about to be
// loaded and steps to the following beat (FIXED / INCR / WRAP) when told to.
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [63:0] i_start_addr,
    input  logic [7:0]  i_len,
    input  logic [1:0]  i_burst,
    output logic [63:0] o_addr,
    output logic        o_last,
    output logic        o_wrap_err
);

    logic [63:0] r_addr;
    logic [7:0]  r_cnt;
    logic [7:0]  r_len;
    logic [1:0]  r_burst;

    logic [63:0] w_addr;
    logic [63:0] w_next;
    logic [63:0] w_mask;
    logic [7:0]  w_len;
    logic [7:0]  w_cnt;
    logic [1:0]  w_burst;

    // A load and a step may coincide, so the first beat is taken straight from the inputs.
    assign w_addr  = i_load ? i_start_addr : r_addr;
    assign w_len   = i_load ? i_len : r_len;
    assign w_cnt   = i_load ? i_len : r_cnt;
    assign w_burst = i_load ? i_burst : r_burst;

    // Wrap window is (len+1)*8 bytes, i.e. mask = len*8 + 7.
    assign w_mask = {53'd0, w_len, 3'b111};

    always_comb begin
        w_next = w_addr + 64'd8;
        case (w_burst)
            AXI_BURST_FIXED: w_next = w_addr;
            AXI_BURST_WRAP:  w_next = (w_addr & ~w_mask) | ((w_addr + 64'd8) & w_mask);
            default:         w_next = w_addr + 64'd8;
        endcase
    end

    assign o_addr     = w_addr;
    assign o_last     = (w_cnt == 8'd0);
    assign o_wrap_err = (w_burst == AXI_BURST_WRAP) && !wrap_len_ok(w_len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_burst <= '0;
        end else begin
            if (i_load) begin
                r_len   <= i_len;
                r_burst <= i_burst;
            end
            if (i_step) begin
                r_addr <= w_next;
                r_cnt  <= w_cnt - 8'd1;
            end else if (i_load) begin
                r_addr <= w_addr;
                r_cnt  <= w_cnt;
            end
        end
    end

endmodule

// File: rtl/axi_read_responder.sv
// AXI4 read slave backed by a preloadable 64-bit word array; one burst in flight.
// Optional first-beat latency stage enabled by defining AXI_RESP_LATENCY_EN.
module axi_read_responder
    import axi_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR   = 64'h0,
    parameter int          RESP_LAT    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [63:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    input  logic        mem_wr_en,
    input  logic [63:0] mem_wr_addr,
    input  logic [63:0] mem_wr_data
);

    localparam int AW = $clog2(DEPTH_WORDS);

    rsp_state_e  r_state;
    rsp_state_e  w_state_nxt;

    logic [63:0] r_mem [DEPTH_WORDS];
    logic        r_arready;
    logic        r_rvalid;
    logic        r_rlast;
    logic [1:0]  r_rresp;
    logic [63:0] r_rdata;
    logic        r_burst_err;

    logic        w_ar_hs;
    logic        w_first_now;
    logic        w_lat_done;
    logic        w_load_beat;
    logic        w_beat_last;
    logic        w_wrap_err;
    logic        w_burst_err_now;
    logic        w_err_sel;
    logic        w_in_range;
    logic        w_wr_in_range;
    logic [63:0] w_beat_addr;
    logic [63:0] w_word;
    logic [63:0] w_wr_word;

    assign w_ar_hs         = s_axi_arvalid && r_arready;
    assign w_burst_err_now = (s_axi_arsize != AXI_SIZE_8B) || (s_axi_arburst == 2'b11) || w_wrap_err;

`ifdef AXI_RESP_LATENCY_EN
    localparam bit LAT_SKIP = (RESP_LAT == 0);
    logic [7:0] r_lat_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lat_cnt <= '0;
        end else if (w_ar_hs) begin
            r_lat_cnt <= 8'(RESP_LAT - 1);
        end else if (r_state == RSP_LAT && r_lat_cnt != 8'd0) begin
            r_lat_cnt <= r_lat_cnt - 8'd1;
        end
    end

    assign w_lat_done  = (r_state == RSP_LAT) && (r_lat_cnt == 8'd0);
    assign w_first_now = LAT_SKIP ? w_ar_hs : w_lat_done;
`else
    assign w_lat_done  = 1'b0;
    assign w_first_now = w_ar_hs;
`endif

    assign w_load_beat = w_first_now || ((r_state == RSP_BURST) && s_axi_rready && !r_rlast);
    // The first beat can load in the same cycle as the AR handshake, before r_burst_err is written.
    assign w_err_sel   = (r_state == RSP_IDLE) ? w_burst_err_now : r_burst_err;

    axi_burst_addr_gen u_addr_gen (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_ar_hs),
        .i_step       (w_load_beat),
        .i_start_addr (s_axi_araddr),
        .i_len        (s_axi_arlen),
        .i_burst      (s_axi_arburst),
        .o_addr       (w_beat_addr),
        .o_last       (w_beat_last),
        .o_wrap_err   (w_wrap_err)
    );

    assign w_word        = (w_beat_addr - BASE_ADDR) >> 3;
    assign w_in_range    = (w_beat_addr >= BASE_ADDR) && (w_word < 64'(DEPTH_WORDS));
    assign w_wr_word     = (mem_wr_addr - BASE_ADDR) >> 3;
    assign w_wr_in_range = (mem_wr_addr >= BASE_ADDR) && (w_wr_word < 64'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (mem_wr_en && w_wr_in_range) begin
            r_mem[w_wr_word[AW-1:0]] <= mem_wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RSP_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RSP_IDLE: begin
                if (w_ar_hs) begin
`ifdef AXI_RESP_LATENCY_EN
                    w_state_nxt = LAT_SKIP ? RSP_BURST : RSP_LAT;
`else
                    w_state_nxt = RSP_BURST;
`endif
                end
            end
            RSP_LAT: begin
                if (w_lat_done) begin
                    w_state_nxt = RSP_BURST;
                end
            end
            RSP_BURST: begin
                if (s_axi_rready && r_rlast) begin
                    w_state_nxt = RSP_IDLE;
                end
            end
            default: w_state_nxt = RSP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rresp     <= AXI_RESP_OKAY;
            r_rdata     <= '0;
            r_burst_err <= 1'b0;
        end else begin
            r_arready <= (w_state_nxt == RSP_IDLE);
            r_rvalid  <= (w_state_nxt == RSP_BURST);
            if (w_ar_hs) begin
                r_burst_err <= w_burst_err_now;
            end
            if (w_load_beat) begin
                r_rlast <= w_beat_last;
                if (w_err_sel || !w_in_range) begin
                    r_rdata <= '0;
                    r_rresp <= AXI_RESP_SLVERR;
                end else begin
                    r_rdata <= r_mem[w_word[AW-1:0]];
                    r_rresp <= AXI_RESP_OKAY;
                end
            end else if (w_state_nxt == RSP_IDLE) begin
                r_rlast <= 1'b0;
            end
        end
    end

    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;

endmodule

// File: tb/tb_axi_read_responder.sv
// Scoreboard bench for axi_read_responder: a burst model pushes expected beats, a monitor pops them.
module tb_axi_read_responder;

    localparam int DEPTH = 4096;
`ifdef AXI_RESP_LATENCY_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        bit          chk_data;
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [63:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b1;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        mem_wr_en;
    logic [63:0] mem_wr_addr;
    logic [63:0] mem_wr_data;

    axi_read_responder #(
        .DEPTH_WORDS (DEPTH),
        .BASE_ADDR   (64'h0),
        .RESP_LAT    (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .mem_wr_en     (mem_wr_en),
        .mem_wr_addr   (mem_wr_addr),
        .mem_wr_data   (mem_wr_data)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    beat_t       exp_q[$];
    logic [63:0] ref_mem [DEPTH];
    int          t_ar = 0;
    int          t_first = -1;
    int          t_last = -1;
    int          beats_seen = 0;
    int          rmode = 0;
    string       cur_tag = "none";
    bit          stalled = 0;
    logic [63:0] h_data;
    logic [1:0]  h_resp;
    logic        h_last;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_tag, name, act, exp);
        end
    endfunction

    // Reference: beat addresses from plain arithmetic over the burst rules.
    task automatic push_expected(input logic [63:0] addr, input logic [7:0] len,
                                 input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] bytes;
        logic [63:0] base;
        bit          whole;
        bytes = (64'(len) + 64'd1) * 64'd8;
        whole = (size != 3'd3) || (burst == 2'b11) ||
                (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        for (int i = 0; i <= int'(len); i++) begin
            logic [63:0] a;
            beat_t       b;
            case (burst)
                2'b00: a = addr;
                2'b10: begin
                    base = addr - (addr % bytes);
                    a = base + (((addr - base) + 64'(8 * i)) % bytes);
                end
                default: a = addr + 64'(8 * i);
            endcase
            b.last = (i == int'(len));
            if (whole) begin
                b.resp = 2'b10; b.data = '0; b.chk_data = 1'b0;
            end else if (a >= 64'(DEPTH * 8)) begin
                b.resp = 2'b10; b.data = '0; b.chk_data = 1'b1;
            end else begin
                b.resp = 2'b00; b.data = ref_mem[a[14:3]]; b.chk_data = 1'b1;
            end
            exp_q.push_back(b);
        end
    endtask

    always @(posedge clk) begin
        int k;
        #1;
        k = cyc - (t_ar + 1 + LAT);
        case (rmode)
            1: s_axi_rready = (k < 0) ? 1'b1 : ((k % 4) == 0 || (k % 4) == 3);
            2: s_axi_rready = (k < 0) ? 1'b1 : 1'($urandom_range(0, 1));
            default: s_axi_rready = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        beat_t e;
        if (!reset_n) begin
            stalled = 0;
        end else begin
            if (stalled) begin
                checks++;
                if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== h_data ||
                    s_axi_rresp !== h_resp || s_axi_rlast !== h_last) begin
                    errors++;
                    $display("FAIL %s/stall_hold: got v=%0b d=%0h r=%0h l=%0b expected v=1 d=%0h r=%0h l=%0b",
                             cur_tag, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast, h_data, h_resp, h_last);
                end
            end
            stalled = 0;
            if (s_axi_rvalid === 1'b1) begin
                if (t_first < 0) t_first = cyc;
                if (s_axi_rready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL %s/unexpected_beat: got data %0h expected no beat", cur_tag, s_axi_rdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.chk_data) check("beat_data", s_axi_rdata, e.data);
                        check("beat_resp", 64'(s_axi_rresp), 64'(e.resp));
                        check("beat_last", 64'(s_axi_rlast), 64'(e.last));
                        beats_seen++;
                        if (e.last) t_last = cyc;
                    end
                end else begin
                    stalled = 1;
                    h_data = s_axi_rdata;
                    h_resp = s_axi_rresp;
                    h_last = s_axi_rlast;
                end
            end
        end
    end

    task automatic issue_ar(input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, output bit ok);
        int n;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (s_axi_arready !== 1'b1 && n < 50);
        ok = (s_axi_arready === 1'b1);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s/ar_timeout: got arready=%0b expected 1 within 50 cycles", cur_tag, s_axi_arready);
        end
        t_ar = cyc;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic run_burst(input string tag, input logic [63:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst,
                             input int mode, input bit collide);
        int          n;
        bit          ok;
        logic [63:0] new_data;
        cur_tag    = tag;
        push_expected(addr, len, size, burst);
        beats_seen = 0;
        t_first    = -1;
        t_last     = -1;
        rmode      = mode;
        issue_ar(addr, len, size, burst, ok);
        if (!ok) begin
            exp_q.delete();
            return;
        end
        if (collide) begin
            repeat (LAT) begin @(posedge clk); #1; end
            new_data    = {$urandom, $urandom};
            mem_wr_en   = 1'b1;
            mem_wr_addr = addr + 64'd8;
            mem_wr_data = new_data;
            @(posedge clk); #1;
            mem_wr_en   = 1'b0;
            ref_mem[(addr + 64'd8) >> 3] = new_data;
        end
        n = 0;
        while (beats_seen < int'(len) + 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (beats_seen < int'(len) + 1) begin
            checks++;
            errors++;
            $display("FAIL %s/drain_timeout: got %0d beats expected %0d", tag, beats_seen, int'(len) + 1);
            exp_q.delete();
            return;
        end
        while (cyc <= t_last) @(negedge clk);
        check("arready_after_last", 64'(s_axi_arready), 64'd1);
        check("rvalid_after_last", 64'(s_axi_rvalid), 64'd0);
        check("first_beat_cycle", 64'(t_first), 64'(t_ar + 1 + LAT));
        if (mode == 0) check("back_to_back", 64'(t_last - t_first), 64'(len));
    endtask

    initial begin
        bit ok;
        int n;
        reset_n       = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arsize  = 3'd3;
        s_axi_arburst = 2'b01;
        mem_wr_en     = 1'b0;
        mem_wr_addr   = '0;
        mem_wr_data   = '0;

        cur_tag = "reset";
        repeat (3) @(posedge clk);
        #3;
        check("arready", 64'(s_axi_arready), 64'd0);
        check("rvalid", 64'(s_axi_rvalid), 64'd0);
        check("rlast", 64'(s_axi_rlast), 64'd0);
        check("rresp", 64'(s_axi_rresp), 64'd0);
        check("rdata", s_axi_rdata, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("arready_before_edge", 64'(s_axi_arready), 64'd0);
        @(negedge clk);
        check("arready_first_clock", 64'(s_axi_arready), 64'd1);

        @(posedge clk); #1;
        mem_wr_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            mem_wr_addr = 64'(i) * 64'd8;
            mem_wr_data = {$urandom, $urandom};
            ref_mem[i]  = mem_wr_data;
            @(posedge clk); #1;
        end
        for (int i = 0; i < 4; i++) begin
            mem_wr_addr = 64'h1000 + 64'(i * 8);
            mem_wr_data = 64'hA0 + 64'(i);
            ref_mem[(64'h1000 >> 3) + i] = mem_wr_data;
            @(posedge clk); #1;
        end
        mem_wr_en = 1'b0;

        run_burst("incr4",        64'h1000, 8'd3, 3'd3, 2'b01, 0, 1'b0);
        run_burst("wrap4",        64'h1010, 8'd3, 3'd3, 2'b10, 0, 1'b0);
        run_burst("backpressure", 64'h1000, 8'd3, 3'd3, 2'b01, 1, 1'b0);
        run_burst("err_edge",     64'((DEPTH - 1) * 8), 8'd1, 3'd3, 2'b01, 0, 1'b0);
        run_burst("err_size",     64'h2000, 8'd3, 3'd2, 2'b01, 0, 1'b0);
        run_burst("err_wrap_len", 64'h2000, 8'd2, 3'd3, 2'b10, 0, 1'b0);
        run_burst("err_burst11",  64'h2000, 8'd1, 3'd3, 2'b11, 0, 1'b0);
        run_burst("fixed",        64'h3008, 8'd3, 3'd3, 2'b00, 1, 1'b0);
        run_burst("wrap8_unalig", 64'h3035, 8'd7, 3'd3, 2'b10, 2, 1'b0);
        run_burst("collide",      64'h4000, 8'd3, 3'd3, 2'b01, 0, 1'b1);
        run_burst("after_coll",   64'h4008, 8'd0, 3'd3, 2'b01, 0, 1'b0);
        run_burst("incr256",      64'h0,    8'd255, 3'd3, 2'b01, 0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            logic [63:0] a;
            logic [7:0]  l;
            a = 64'($urandom_range(0, DEPTH + 8)) * 64'd8;
            if ($urandom_range(0, 3) == 0) a = a + 64'($urandom_range(0, 7));
            l = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 15));
            run_burst("random", a, l, ($urandom_range(0, 9) == 0) ? 3'd2 : 3'd3,
                      2'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
        end

        cur_tag = "reset_mid";
        push_expected(64'h2000, 8'd7, 3'd3, 2'b01);
        beats_seen = 0;
        t_first    = -1;
        rmode      = 0;
        issue_ar(64'h2000, 8'd7, 3'd3, 2'b01, ok);
        n = 0;
        while (beats_seen < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("beats_before_reset", 64'(beats_seen >= 2), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rvalid_in_reset", 64'(s_axi_rvalid), 64'd0);
        check("arready_in_reset", 64'(s_axi_arready), 64'd0);
        check("rlast_in_reset", 64'(s_axi_rlast), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("arready_after_release", 64'(s_axi_arready), 64'd1);
        check("rvalid_after_release", 64'(s_axi_rvalid), 64'd0);
        run_burst("post_reset", 64'h1008, 8'd0, 3'd3, 2'b01, 0, 1'b0);

        repeat (3) @(negedge clk);
        cur_tag = "end";
        check("no_leftover_beats", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
